// File: rtl/ppu_pkg.sv
// Shared definitions for the pixel pipeline: pixel record layout, tile-row
// width and the default attribute width.
package ppu_pkg;

   // Pixels in one decoded tile row.
   localparam int PX_ROW = 8;

   // Default per-pixel attribute width (palette, priority, source).
   localparam int ATTR_W_DEF = 3;

   // One pixel at the default attribute width. Wider or narrower attribute
   // configurations keep the same field order: colour in the top two bits,
   // attribute below it.
   typedef struct packed {
      logic [1:0]            color;
      logic [ATTR_W_DEF-1:0] attr;
   } px_t;

   // Colour index of one row pixel from its bitplanes. Pixel 0 is the
   // leftmost on screen, which is bit 7 unless the row is mirrored.
   function automatic logic [1:0] row_px_color(input logic [7:0] lo,
                                               input logic [7:0] hi,
                                               input logic       flip,
                                               input int         i);
      logic [2:0] b;
      b = flip ? 3'(i) : 3'(PX_ROW - 1 - i);
      return {hi[b], lo[b]};
   endfunction

endpackage : ppu_pkg

// File: rtl/px_row_decode.sv
// Combinational tile-row decoder: two bitplanes plus a shared attribute
// expand into eight {colour, attr} pixels, leftmost pixel in slot 0.
module px_row_decode
   import ppu_pkg::*;
#(
   parameter int ATTR_W = ATTR_W_DEF
) (
   input  logic [7:0]                     lo,
   input  logic [7:0]                     hi,
   input  logic [ATTR_W-1:0]              attr,
   input  logic                           flip,
   output logic [PX_ROW-1:0][ATTR_W+1:0]  px
);

   // Expand every pixel of the row; the attribute is common to the whole row.
   always_comb begin
      px = '0;
      for (int i = 0; i < PX_ROW; i++) begin
         px[i] = {row_px_color(lo, hi, flip, i), attr};
      end
   end

endmodule : px_row_decode

// File: rtl/pixel_fifo.sv
// Pixel FIFO for the background/sprite pipeline. Whole tile rows (8 pixels)
// are pushed at the tail, single pixels are popped from the head, and a
// sprite row may be overlaid onto the 8 head pixels where the background is
// transparent (colour 00).
//
// Handshake: a transfer happens on a rising edge exactly when valid and
// ready are both high in the cycle before it; ready never depends on the
// same channel's valid, and valid may be raised or dropped at any time.
// The pop side is the same contract with px_valid as the ready-like signal
// and pop_en as the request.
module pixel_fifo
   import ppu_pkg::*;
#(
   parameter int DEPTH  = 16,
   parameter int ATTR_W = ATTR_W_DEF
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    flush,

   input  logic                    push_valid,
   output logic                    push_ready,
   input  logic [7:0]              push_lo,
   input  logic [7:0]              push_hi,
   input  logic [ATTR_W-1:0]       push_attr,
   input  logic                    push_flip,

   input  logic                    merge_valid,
   output logic                    merge_ready,
   input  logic [7:0]              merge_lo,
   input  logic [7:0]              merge_hi,
   input  logic [ATTR_W-1:0]       merge_attr,
   input  logic                    merge_flip,

   input  logic                    pop_en,
   output logic [1:0]              px_color,
   output logic [ATTR_W-1:0]       px_attr,
   output logic                    px_valid,

   output logic [$clog2(DEPTH):0]  count,
   output logic                    full,
   output logic                    empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam int EW = ATTR_W + 2;

   localparam logic [PW-1:0] ROW_CNT   = PW'(PX_ROW);
   localparam logic [PW-1:0] PUSH_LIM  = PW'(DEPTH - PX_ROW);

   // Pointers carry one wrap bit above the slot index so that full and
   // empty can be told apart when the slot indices are equal.
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [AW-1:0] wr_idx;
   logic [AW-1:0] rd_idx;

   // Pixel storage, {colour, attr} per entry. Not reset: stale entries are
   // never observable because the head output is masked while empty.
   logic [EW-1:0] mem [DEPTH];

   logic [PX_ROW-1:0][EW-1:0] push_px;
   logic [PX_ROW-1:0][EW-1:0] merge_px;

   logic          merge_fire;
   logic          push_fire;
   logic          pop_fire;
   logic [EW-1:0] head_px;

   // ---------------------------------------------------------------------
   // Row decoders for the two row-wide inputs
   // ---------------------------------------------------------------------
   px_row_decode #(.ATTR_W(ATTR_W)) u_push_dec (
      .lo   (push_lo),
      .hi   (push_hi),
      .attr (push_attr),
      .flip (push_flip),
      .px   (push_px)
   );

   px_row_decode #(.ATTR_W(ATTR_W)) u_merge_dec (
      .lo   (merge_lo),
      .hi   (merge_hi),
      .attr (merge_attr),
      .flip (merge_flip),
      .px   (merge_px)
   );

   // ---------------------------------------------------------------------
   // Occupancy and handshake decode
   // ---------------------------------------------------------------------
   assign wr_idx = wr_ptr[AW-1:0];
   assign rd_idx = rd_ptr[AW-1:0];

   // Occupancy comes straight from the pointer difference; the wrap bit
   // makes the subtraction exact over the full 0..DEPTH range.
   always_comb begin
      count = wr_ptr - rd_ptr;
      empty = (wr_ptr == rd_ptr);
      full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_idx == rd_idx);
   end

   // Flush outranks merge, which outranks push and pop. A merge rewrites the
   // head entries in place, so pushes and pops are held off while it fires.
   always_comb begin
      merge_ready = (count >= ROW_CNT) && !flush;
      merge_fire  = merge_valid && merge_ready;
      push_ready  = (count <= PUSH_LIM) && !merge_fire && !flush;
      push_fire   = push_valid && push_ready;
      px_valid    = !empty && !merge_fire;
      pop_fire    = pop_en && px_valid;
   end

   // Head pixel is read combinationally and forced to zero while empty.
   always_comb begin
      head_px  = mem[rd_idx];
      px_color = empty ? 2'b00 : head_px[EW-1:EW-2];
      px_attr  = empty ? '0 : head_px[ATTR_W-1:0];
   end

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   // Pointer update: flush clears, push advances the tail by a whole row,
   // pop advances the head by one pixel; both may happen together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push_fire) wr_ptr <= wr_ptr + ROW_CNT;
         if (pop_fire)  rd_ptr <= rd_ptr + PW'(1);
      end
   end

   // Storage write: a push fills 8 slots from the tail (wrapping), a merge
   // fills only transparent head slots with non-transparent sprite pixels.
   always_ff @(posedge clk) begin
      for (int k = 0; k < PX_ROW; k++) begin
         if (push_fire) begin
            mem[wr_idx + AW'(k)] <= push_px[k];
         end else if (merge_fire) begin
            if ((mem[rd_idx + AW'(k)][EW-1:EW-2] == 2'b00) &&
                (merge_px[k][EW-1:EW-2] != 2'b00)) begin
               mem[rd_idx + AW'(k)] <= merge_px[k];
            end
         end
      end
   end

   // ---------------------------------------------------------------------
   // Structural invariants
   // ---------------------------------------------------------------------
   // Occupancy can never exceed the storage size.
   a_count_bound : assert property (@(posedge clk) disable iff (rst)
      count <= PW'(DEPTH));

   // A row push and a merge are never accepted in the same cycle.
   a_push_merge_excl : assert property (@(posedge clk) disable iff (rst)
      !(push_fire && merge_fire));

   // An accepted push always has a full row of free space.
   a_push_room : assert property (@(posedge clk) disable iff (rst)
      push_fire |-> (count <= PUSH_LIM));

endmodule : pixel_fifo

// File: tb/tb_pixel_fifo.sv
// Directed and scoreboarded bench for pixel_fifo (DEPTH=16, ATTR_W=3).
module tb_pixel_fifo;
  import ppu_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       flush, push_valid, push_ready, push_flip;
  logic [7:0] push_lo, push_hi;
  logic [2:0] push_attr;
  logic       merge_valid, merge_ready, merge_flip;
  logic [7:0] merge_lo, merge_hi;
  logic [2:0] merge_attr;
  logic       pop_en, px_valid;
  logic [1:0] px_color;
  logic [2:0] px_attr;
  logic [4:0] count;
  logic       full, empty;

  pixel_fifo #(.DEPTH(16), .ATTR_W(3)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .push_valid(push_valid), .push_ready(push_ready),
    .push_lo(push_lo), .push_hi(push_hi), .push_attr(push_attr), .push_flip(push_flip),
    .merge_valid(merge_valid), .merge_ready(merge_ready),
    .merge_lo(merge_lo), .merge_hi(merge_hi), .merge_attr(merge_attr), .merge_flip(merge_flip),
    .pop_en(pop_en), .px_color(px_color), .px_attr(px_attr), .px_valid(px_valid),
    .count(count), .full(full), .empty(empty)
  );

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  // Observed outputs packed as {count, px_valid, px_color, px_attr, push_ready, merge_ready, full, empty}
  function automatic logic [14:0] pack_obs();
    return {count, px_valid, px_color, px_attr, push_ready, merge_ready, full, empty};
  endfunction

  function automatic logic [14:0] pack_exp(input int cnt, input logic pv, input logic [1:0] col,
                                           input logic [2:0] at, input logic pr, input logic mr);
    return {5'(cnt), pv, col, at, pr, mr, (cnt == 16), (cnt == 0)};
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    logic       push;
    logic [7:0] lo, hi;
    logic [2:0] at;
    logic       fl;
    logic       mv;
    logic [7:0] mlo, mhi;
    logic [2:0] mat;
    logic       pop;
    logic       fsh;
    logic [14:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic push, input logic [7:0] lo, input logic [7:0] hi,
                              input logic [2:0] at, input logic fl, input logic mv,
                              input logic [7:0] mlo, input logic [7:0] mhi, input logic [2:0] mat,
                              input logic pop, input logic fsh, input int cnt, input logic pv,
                              input logic [1:0] col, input logic [2:0] ea, input logic pr,
                              input logic mr);
    vec_t v;
    v.push = push; v.lo = lo; v.hi = hi; v.at = at; v.fl = fl;
    v.mv = mv; v.mlo = mlo; v.mhi = mhi; v.mat = mat;
    v.pop = pop; v.fsh = fsh;
    v.exp = pack_exp(cnt, pv, col, ea, pr, mr);
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    flush = 0; push_valid = 0; push_lo = 0; push_hi = 0; push_attr = 0; push_flip = 0;
    merge_valid = 0; merge_lo = 0; merge_hi = 0; merge_attr = 0; merge_flip = 0;
    pop_en = 0;
  endtask

  task automatic drive_vec(input vec_t v);
    push_valid = v.push; push_lo = v.lo; push_hi = v.hi; push_attr = v.at; push_flip = v.fl;
    merge_valid = v.mv; merge_lo = v.mlo; merge_hi = v.mhi; merge_attr = v.mat; merge_flip = 0;
    pop_en = v.pop; flush = v.fsh;
  endtask

  // Independent model of one decoded pixel {colour, attr}
  function automatic logic [4:0] dec(input logic [7:0] lo, input logic [7:0] hi,
                                     input logic [2:0] at, input logic fl, input int i);
    int b;
    b = fl ? i : 7 - i;
    return {hi[b], lo[b], at};
  endfunction

  // ---------------- scoreboard ----------------
  logic [4:0] exp_q[$];

  int cols_a[8] = '{0, 2, 3, 3, 3, 3, 2, 0};

  initial begin
    px_t   rnd_px;
    string nm;
    rst = 1'b1;
    drive_idle();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // ---- table: reset state, decode, flip, merge, dropped pops, flush ----
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(1, 8'h3C, 8'h7E, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    for (int j = 0; j < 8; j++)
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 8 - j, 1, 2'(cols_a[j]), 0, 1, (j == 0)));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(1, 8'h01, 8'h00, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    for (int j = 0; j < 8; j++)
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 8 - j, 1, (j == 0) ? 2'd1 : 2'd0, 5, 1, (j == 0)));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(1, 8'hF0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    // merge with pop_en: pop dropped, head still shown, push blocked
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 8'hFF, 8'hFF, 1, 1, 0, 8, 0, 1, 0, 0, 1));
    for (int j = 0; j < 8; j++)
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 8 - j, 1,
                        (j < 4) ? 2'd1 : 2'd3, (j < 4) ? 3'd0 : 3'd1, 1, (j == 0)));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0));  // pop while empty
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(1, 8'h3C, 8'h7E, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));  // push + flush
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(1, 8'h3C, 8'h7E, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 8, 1, 0, 0, 0, 0));  // flush + pop
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));

    foreach (vecs[i]) begin
      @(negedge clk);
      drive_vec(vecs[i]);
      #2;
      nm = $sformatf("vec%0d", i);
      check(nm, 32'(pack_obs()), 32'(vecs[i].exp));
    end

    // ---- full / backpressure with push held, then wrap-around readout ----
    @(negedge clk);
    drive_idle();
    push_valid = 1; push_lo = 8'h3C; push_hi = 8'h7E; push_attr = 0;
    #2 check("fill_pr0", 32'(push_ready), 32'd1);
    @(negedge clk);
    push_lo = 8'hFF; push_hi = 8'h00; push_attr = 2;
    #2 check("fill_pr1", 32'(push_ready), 32'd1);
    @(negedge clk);
    push_lo = 8'h00; push_hi = 8'hFF; push_attr = 4;
    #2 check("full_state", 32'({count, full, push_ready}), 32'({5'd16, 1'b1, 1'b0}));
    for (int j = 0; j < 9; j++) begin
      if (j > 0) @(negedge clk);
      pop_en = 1;
      #2;
      nm = $sformatf("bp%0d", j);
      check(nm, 32'({count, push_ready, px_color}),
            32'({5'(16 - j), (16 - j) <= 8, (j < 8) ? 2'(cols_a[j]) : 2'd1}));
    end
    @(negedge clk);
    drive_idle();
    #2 check("bp_cnt15", 32'(count), 32'd15);
    for (int j = 0; j < 15; j++) begin
      if (j > 0) @(negedge clk);
      pop_en = 1;
      #2;
      nm = $sformatf("wrap%0d", j);
      check(nm, 32'({px_color, px_attr}), (j < 7) ? 32'({2'd1, 3'd2}) : 32'({2'd2, 3'd4}));
    end
    @(negedge clk);
    drive_idle();
    #2 check("wrap_empty", 32'({count, empty}), 32'({5'd0, 1'b1}));

    // ---- asynchronous reset in the middle of a merge ----
    push_valid = 1; push_lo = 8'h00; push_hi = 8'h00; push_attr = 0;
    @(negedge clk);
    drive_idle();
    merge_valid = 1; merge_lo = 8'hFF; merge_hi = 8'h00; merge_attr = 3;
    push_valid = 1; push_lo = 8'hAA; push_hi = 8'h55;
    #2 rst = 1'b1;
    #1 check("async_rst", 32'(pack_obs()), 32'(pack_exp(0, 0, 0, 0, 1, 0)));
    @(negedge clk);
    drive_idle();
    rst = 1'b0;
    #2 check("post_rst", 32'(pack_obs()), 32'(pack_exp(0, 0, 0, 0, 1, 0)));

    // ---- random traffic against the queue model ----
    exp_q.delete();
    for (int c = 0; c < 100; c++) begin
      int         cnt;
      logic       mf, pr, mr, pv;
      logic [1:0] ecol;
      logic [2:0] eat;
      @(negedge clk);
      push_valid  = ($urandom_range(0, 1) == 1);
      push_lo     = 8'($urandom_range(0, 255));
      push_hi     = 8'($urandom_range(0, 255));
      push_attr   = 3'($urandom_range(0, 7));
      push_flip   = ($urandom_range(0, 1) == 1);
      merge_valid = ($urandom_range(0, 3) == 0);
      merge_lo    = 8'($urandom_range(0, 255));
      merge_hi    = 8'($urandom_range(0, 255));
      merge_attr  = 3'($urandom_range(0, 7));
      merge_flip  = ($urandom_range(0, 1) == 1);
      pop_en      = ($urandom_range(0, 1) == 1);
      flush       = ($urandom_range(0, 24) == 0);
      #2;
      cnt  = exp_q.size();
      mf   = merge_valid && (cnt >= 8) && !flush;
      mr   = (cnt >= 8) && !flush;
      pr   = (cnt <= 8) && !mf && !flush;
      pv   = (cnt > 0) && !mf;
      rnd_px = (cnt > 0) ? exp_q[0] : 5'd0;
      ecol = rnd_px.color;
      eat  = rnd_px.attr;
      nm = $sformatf("rand%0d", c);
      check(nm, 32'(pack_obs()), 32'(pack_exp(cnt, pv, ecol, eat, pr, mr)));
      if (flush) begin
        exp_q.delete();
      end else if (mf) begin
        for (int k = 0; k < 8; k++) begin
          logic [4:0] m;
          m = dec(merge_lo, merge_hi, merge_attr, merge_flip, k);
          if (exp_q[k][4:3] == 2'b00 && m[4:3] != 2'b00) exp_q[k] = m;
        end
      end else begin
        if (pop_en && pv) void'(exp_q.pop_front());
        if (push_valid && pr)
          for (int k = 0; k < 8; k++) exp_q.push_back(dec(push_lo, push_hi, push_attr, push_flip, k));
      end
    end

    @(negedge clk);
    drive_idle();

    // ---------------- report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_pixel_fifo
